// File: rtl/wbm_pkg.sv
// wbm_pkg: shared state type, default widths and statistics counter width for the Wishbone command initiator
package wbm_pkg;
   typedef enum logic [1:0] {IDLE, BUS, RSP} state_e;
   localparam int DEF_ADR_W = 32;
   localparam int DEF_DAT_W = 32;
   localparam int STAT_W = 16;
endpackage

// File: rtl/wbm_cmd_initiator_if.sv
// wbm_cmd_initiator_if: command, response and Wishbone master signals; master = initiator view, slave = environment view
interface wbm_cmd_initiator_if
   import wbm_pkg::*;
#(
   parameter int ADR_W = DEF_ADR_W,
   parameter int DAT_W = DEF_DAT_W
);
   logic               cmd_valid_i;
   logic               cmd_ready_o;
   logic               cmd_we_i;
   logic [ADR_W-1:0]   cmd_adr_i;
   logic [DAT_W-1:0]   cmd_dat_i;
   logic [DAT_W/8-1:0] cmd_sel_i;
   logic               rsp_valid_o;
   logic               rsp_ready_i;
   logic [DAT_W-1:0]   rsp_dat_o;
   logic               rsp_err_o;
   logic               wbm_cyc_o;
   logic               wbm_stb_o;
   logic               wbm_we_o;
   logic [ADR_W-1:0]   wbm_adr_o;
   logic [DAT_W-1:0]   wbm_dat_o;
   logic [DAT_W/8-1:0] wbm_sel_o;
   logic [DAT_W-1:0]   wbm_dat_i;
   logic               wbm_ack_i;
   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i, wbm_dat_i, wbm_ack_i,
      output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
   );
   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i, wbm_dat_i, wbm_ack_i,
      input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
   );
endinterface

// File: rtl/wbm_timeout_cnt.sv
// wbm_timeout_cnt: counts cycles while run_i is high; expired_o pulses on the last allowed cycle, never when TIMEOUT_CYC = 0
module wbm_timeout_cnt #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic run_i,
   input  logic clear_i,
   output logic expired_o
);
   localparam int W = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk) cnt_q <= clear_i ? '0 : run_i ? cnt_q + 1'b1 : cnt_q;
   assign expired_o = (TIMEOUT_CYC != 0) && run_i && cnt_q == LAST;
endmodule

// File: rtl/wbm_cmd_initiator.sv
// wbm_cmd_initiator: one guarded Wishbone classic cycle per command, result returned over a valid/ready response port.
// Optional hit/error statistics counters are enabled by defining WBM_CMD_INITIATOR_STATS_EN.
module wbm_cmd_initiator
   import wbm_pkg::*;
#(
   parameter int ADR_W = DEF_ADR_W,
   parameter int DAT_W = DEF_DAT_W,
   parameter int TIMEOUT_CYC = 16
) (
   input logic wb_clk_i,
   input logic wb_rst_ni,
   input logic active_i,
   wbm_cmd_initiator_if.master bus
`ifdef WBM_CMD_INITIATOR_STATS_EN
   ,
   input  logic              stat_clr_i,
   output logic [STAT_W-1:0] stat_ack_cnt_o,
   output logic [STAT_W-1:0] stat_err_cnt_o
`endif
);
   state_e             state_q;
   logic               cmd_ready_q, rsp_valid_q, rsp_err_q, cyc_q, we_q;
   logic [DAT_W-1:0]   rsp_dat_q, dat_q;
   logic [ADR_W-1:0]   adr_q;
   logic [DAT_W/8-1:0] sel_q;
   logic               in_bus, expired, bus_ack, bus_err;
   assign in_bus  = state_q == BUS;
   assign bus_ack = in_bus && bus.wbm_ack_i;
   // ack wins over a simultaneous timeout or abort
   assign bus_err = in_bus && !bus.wbm_ack_i && (expired || !active_i);
   wbm_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk(wb_clk_i), .run_i(in_bus), .clear_i(!in_bus), .expired_o(expired)
   );
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cmd_ready_q <= active_i;
               if (bus.cmd_valid_i && cmd_ready_q) begin
                  state_q     <= BUS;
                  cmd_ready_q <= 1'b0;
                  cyc_q       <= 1'b1;
                  we_q        <= bus.cmd_we_i;
                  adr_q       <= bus.cmd_adr_i;
                  dat_q       <= bus.cmd_dat_i;
                  sel_q       <= bus.cmd_sel_i;
               end
            end
            BUS: if (bus_ack || bus_err) begin
               state_q     <= RSP;
               cyc_q       <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= bus_err;
               rsp_dat_q   <= bus_ack && !we_q ? bus.wbm_dat_i : '0;
            end
            default: if (bus.rsp_ready_i) begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               cmd_ready_q <= active_i;
            end
         endcase
      end
   end
   assign bus.cmd_ready_o = cmd_ready_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_dat_o   = rsp_dat_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.wbm_cyc_o   = cyc_q;
   assign bus.wbm_stb_o   = cyc_q;
   assign bus.wbm_we_o    = we_q;
   assign bus.wbm_adr_o   = adr_q;
   assign bus.wbm_dat_o   = dat_q;
   assign bus.wbm_sel_o   = sel_q;
`ifdef WBM_CMD_INITIATOR_STATS_EN
   logic [STAT_W-1:0] ack_cnt_q, err_cnt_q;
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni || stat_clr_i) begin
         ack_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (bus_ack && ack_cnt_q != '1) ack_cnt_q <= ack_cnt_q + 1'b1;
         if (bus_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end
   assign stat_ack_cnt_o = ack_cnt_q;
   assign stat_err_cnt_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_wbm_cmd_initiator.sv
// tb_wbm_cmd_initiator: directed self-checking bench for wbm_cmd_initiator (TIMEOUT_CYC = 16).
// Define WBM_CMD_INITIATOR_STATS_EN to also exercise the statistics counters.
module tb_wbm_cmd_initiator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic active = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc_n;
   wbm_cmd_initiator_if #(.ADR_W(32), .DAT_W(32)) bus ();
`ifdef WBM_CMD_INITIATOR_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] ack_cnt, err_cnt;
`endif
   wbm_cmd_initiator #(.ADR_W(32), .DAT_W(32), .TIMEOUT_CYC(16)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .active_i(active), .bus(bus)
`ifdef WBM_CMD_INITIATOR_STATS_EN
      , .stat_clr_i(stat_clr), .stat_ack_cnt_o(ack_cnt), .stat_err_cnt_o(err_cnt)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = we;
      bus.cmd_adr_i   = adr;
      bus.cmd_dat_i   = dat;
      bus.cmd_sel_i   = sel;
      for (int i = 0; i < 20 && !bus.cmd_ready_o; i++) tick();
      check("issue_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask
   // slave model: ack on the n_ack-th cycle of cyc (0 = never), report cycles cyc was high
   task automatic run_bus(input int n_ack, input logic [31:0] rdata, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, output int cnt);
      logic ok = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40 && bus.wbm_cyc_o; i++) begin
         cnt++;
         ok &= bus.wbm_stb_o && bus.wbm_we_o == we && bus.wbm_adr_o == adr && bus.wbm_dat_o == dat && bus.wbm_sel_o == sel;
         bus.wbm_ack_i = (cnt == n_ack);
         bus.wbm_dat_i = rdata;
         tick();
      end
      bus.wbm_ack_i = 1'b0;
      check("bus_stable", {31'd0, ok}, 32'd1);
   endtask
   task automatic finish_rsp();
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      check("rsp_drop", {31'd0, bus.rsp_valid_o}, 32'd0);
      check("ready_back", {31'd0, bus.cmd_ready_o}, {31'd0, active});
   endtask
   task automatic check_rsp(input string tag, input logic err, input logic [31:0] dat);
      check({tag, "_valid"}, {31'd0, bus.rsp_valid_o}, 32'd1);
      check({tag, "_err"}, {31'd0, bus.rsp_err_o}, {31'd0, err});
      check({tag, "_dat"}, bus.rsp_dat_o, dat);
   endtask
   initial begin
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = '0;
      bus.cmd_dat_i   = '0;
      bus.cmd_sel_i   = '0;
      bus.rsp_ready_i = 1'b0;
      bus.wbm_dat_i   = '0;
      bus.wbm_ack_i   = 1'b0;
      tick();
      tick();
      check("rst_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
      check("rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
      check("rst_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("ready_after_rst", {31'd0, bus.cmd_ready_o}, 32'd1);
      bus.wbm_ack_i = 1'b1;
      tick();
      bus.wbm_ack_i = 1'b0;
      check("stray_ack", {31'd0, bus.rsp_valid_o}, 32'd0);
      // write, ack on third bus cycle; read data on the bus must not leak into a write response
      issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
      check("wr_ready_drop", {31'd0, bus.cmd_ready_o}, 32'd0);
      run_bus(3, 32'hFFFF_FFFF, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, cyc_n);
      check("wr_cyc_len", cyc_n, 32'd3);
      check_rsp("wr", 1'b0, 32'h0);
      finish_rsp();
      // read with immediate ack
      issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      run_bus(1, 32'h1234_5678, 1'b0, 32'h3000_0000, 32'h0, 4'hF, cyc_n);
      check("rd_cyc_len", cyc_n, 32'd1);
      check_rsp("rd", 1'b0, 32'h1234_5678);
      finish_rsp();
      // silent slave: timeout after exactly 16 cycles
      issue(1'b0, 32'h3000_0008, 32'h0, 4'h3);
      run_bus(0, 32'hAAAA_5555, 1'b0, 32'h3000_0008, 32'h0, 4'h3, cyc_n);
      check("tmo_cyc_len", cyc_n, 32'd16);
      check_rsp("tmo", 1'b1, 32'h0);
      finish_rsp();
      // ack on the last allowed cycle beats the timeout
      issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
      run_bus(16, 32'hCAFE_F00D, 1'b0, 32'h3000_000C, 32'h0, 4'hF, cyc_n);
      check("ack16_cyc_len", cyc_n, 32'd16);
      check_rsp("ack16", 1'b0, 32'hCAFE_F00D);
      finish_rsp();
      // response back-pressure with a pending command
      issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      run_bus(1, 32'h0BAD_C0DE, 1'b0, 32'h3000_0010, 32'h0, 4'hF, cyc_n);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_adr_i   = 32'h3000_0014;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
         check("hold_dat", bus.rsp_dat_o, 32'h0BAD_C0DE);
         check("hold_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
         check("hold_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
         tick();
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      check("hs_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
      check("hs_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
      check("hs_no_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
      tick();
      bus.cmd_valid_i = 1'b0;
      check("pend_accept", {31'd0, bus.wbm_cyc_o}, 32'd1);
      check("pend_adr", bus.wbm_adr_o, 32'h3000_0014);
      run_bus(1, 32'h5555_AAAA, 1'b0, 32'h3000_0014, 32'h0, 4'hF, cyc_n);
      check_rsp("pend", 1'b0, 32'h5555_AAAA);
      finish_rsp();
      // reset during the second bus cycle discards the transaction
      issue(1'b1, 32'h3000_0018, 32'h1111_2222, 4'h1);
      tick();
      check("pre_rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
      check("mid_rst_stb", {31'd0, bus.wbm_stb_o}, 32'd0);
      check("mid_rst_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
      check("post_rst_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
      // deactivation mid-cycle aborts with an error response
      issue(1'b0, 32'h3000_001C, 32'h0, 4'hF);
      active = 1'b0;
      tick();
      check("abort_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
      check_rsp("abort", 1'b1, 32'h0);
      finish_rsp();
      active = 1'b1;
      tick();
      check("reactivate", {31'd0, bus.cmd_ready_o}, 32'd1);
`ifdef WBM_CMD_INITIATOR_STATS_EN
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 32'h3000_0100 + 32'(i * 4), 32'(i), 4'hF);
         run_bus(2, 32'h0, 1'b1, 32'h3000_0100 + 32'(i * 4), 32'(i), 4'hF, cyc_n);
         finish_rsp();
      end
      for (int i = 0; i < 2; i++) begin
         issue(1'b0, 32'h3000_0200, 32'h0, 4'hF);
         run_bus(0, 32'h0, 1'b0, 32'h3000_0200, 32'h0, 4'hF, cyc_n);
         finish_rsp();
      end
      check("stat_ack", {16'd0, ack_cnt}, 32'd3);
      check("stat_err", {16'd0, err_cnt}, 32'd2);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("stat_ack_clr", {16'd0, ack_cnt}, 32'd0);
      check("stat_err_clr", {16'd0, err_cnt}, 32'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
